// File: rtl/uart_frame_parser_pkg.sv
// uart_pkg: shared constants and enums for the UART frame parser
package uart_pkg;
  localparam logic [7:0] SOF_BYTE = 8'h55;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CHK, COMMIT} frame_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT} frame_err_e;
endpackage

// File: rtl/uart_frame_parser_if.sv
// UartIF: byte handshake from the UART receiver
// data/valid flow master->slave, ready flows slave->master; a byte moves when valid && ready
interface UartIF;
  logic [7:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/uart_frame_parser_buf.sv
// frame_buf: payload store, one write port and one read port with registered output
// ports: clk, rst_n (sync, active-low, clears the read register only);
//        we_i/waddr_i/wdata_i = write port; raddr_i/rdata_o = read port, data one cycle after address
module frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk)
    rdata_q <= !rst_n ? '0 : mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: recovers checksummed write frames from a UART byte stream and replays them as write beats
// ports: clk, rst_n (sync, active-low); in = received bytes (UartIF.slave);
//        wr_valid/wr_ready/wr_addr/wr_data = write burst; frame_ok = frame committed; err_valid/err_code = frame dropped
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  UartIF.slave        in,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_ok,
  output logic        err_valid,
  output logic [1:0]  err_code
);
  localparam longint unsigned TO_CYC = 64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQ) / 64'(BAUD_RATE);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  frame_state_e state_q, state_d;
  frame_err_e err_d;
  logic [TW-1:0] to_q, to_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [7:0] sum_q, sum_d, addr_q, addr_d;
  logic wv_q, wv_d, ok_q, ok_d, ev_q;
  logic [1:0] code_q;
  logic acc, hs, last, timed, we;
  assign in.ready = state_q != COMMIT;
  always_comb begin
    acc = in.valid && in.ready;
    hs = wv_q && wr_ready;
    last = idx_q == len_q - LW'(1);
    timed = state_q inside {ADDR, LEN, DATA, CHK};
    state_d = state_q;
    err_d = ERR_NONE;
    to_d = (timed && !acc) ? to_q + TW'(1) : '0;
    len_d = len_q;
    idx_d = idx_q;
    sum_d = sum_q;
    addr_d = addr_q;
    wv_d = wv_q;
    ok_d = 1'b0;
    we = 1'b0;
    // a byte accepted in the expiry cycle takes priority over the timeout
    if (timed && !acc && to_q == TW'(TO_CYC)) begin
      state_d = IDLE;
      err_d = ERR_TIMEOUT;
    end else begin
      case (state_q)
        IDLE: state_d = (acc && in.data == SOF_BYTE) ? ADDR : IDLE;
        ADDR:
          if (acc) begin
            addr_d = in.data;
            sum_d = in.data;
            state_d = LEN;
          end
        LEN:
          if (acc) begin
            if (in.data == 8'd0 || in.data > 8'(MAX_LEN)) begin
              err_d = ERR_LEN;
              state_d = IDLE;
            end else begin
              len_d = LW'(in.data);
              sum_d = sum_q + in.data;
              idx_d = '0;
              state_d = DATA;
            end
          end
        DATA:
          if (acc) begin
            we = 1'b1;
            sum_d = sum_q + in.data;
            idx_d = last ? '0 : idx_q + LW'(1);
            state_d = last ? CHK : DATA;
          end
        CHK:
          if (acc) begin
            wv_d = in.data == sum_q;
            err_d = in.data == sum_q ? ERR_NONE : ERR_CHK;
            state_d = in.data == sum_q ? COMMIT : IDLE;
          end
        COMMIT:
          if (hs) begin
            wv_d = !last;
            ok_d = last;
            idx_d = last ? '0 : idx_q + LW'(1);
            addr_d = last ? addr_q : addr_q + 8'd1;
            state_d = last ? IDLE : COMMIT;
          end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      to_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      addr_q <= '0;
      wv_q <= 1'b0;
      ok_q <= 1'b0;
      ev_q <= 1'b0;
      code_q <= '0;
    end else begin
      state_q <= state_d;
      to_q <= to_d;
      len_q <= len_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      addr_q <= addr_d;
      wv_q <= wv_d;
      ok_q <= ok_d;
      ev_q <= err_d != ERR_NONE;
      code_q <= err_d;
    end
  end
  // reading at the next-cycle index prefetches each beat so data lines up with wr_valid
  frame_buf #(.DEPTH(MAX_LEN), .AW(IW)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .we_i(we),
    .waddr_i(idx_q[IW-1:0]),
    .wdata_i(in.data),
    .raddr_i(idx_d[IW-1:0]),
    .rdata_o(wr_data)
  );
  assign wr_valid = wv_q;
  assign wr_addr = addr_q;
  assign frame_ok = ok_q;
  assign err_valid = ev_q;
  assign err_code = code_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD = 100_000;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TOB = 4;
  localparam int TO = TOB * 10 * (CLK_FREQ / BAUD);
  logic clk = 0;
  logic rst_n = 0;
  logic wr_ready = 1;
  logic wr_valid, frame_ok, err_valid;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_wr[$];
  logic [3:0] exp_ev[$];
  logic [7:0] pl[$];
  UartIF u_if();
  uart_frame_parser #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .MAX_LEN(MAX_LEN), .TIMEOUT_BYTES(TOB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(u_if),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ok(frame_ok), .err_valid(err_valid), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int t = 0;
    while (!u_if.ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 1000) check("ready_wait", 32'(u_if.ready), 1);
    u_if.data = b;
    u_if.valid = 1'b1;
    @(posedge clk); #1;
    u_if.valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] a, input logic [7:0] flip);
    logic [7:0] s;
    s = a + 8'(pl.size());
    foreach (pl[i]) s = s + pl[i];
    if (flip == 8'd0) begin
      foreach (pl[i]) exp_wr.push_back({8'(a + i), pl[i]});
      exp_ev.push_back(4'b1000);
    end else exp_ev.push_back(4'b0110);
    send(8'h55);
    send(a);
    send(8'(pl.size()));
    foreach (pl[i]) send(pl[i]);
    send(s ^ flip);
  endtask
  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_wr.size() + exp_ev.size()) != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, 32'(exp_wr.size() + exp_ev.size()), 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (wr_valid && wr_ready) begin
        check("wr_pending", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) check("wr_beat", 32'({wr_addr, wr_data}), 32'(exp_wr.pop_front()));
      end
      if (frame_ok || err_valid) begin
        check("ev_pending", 32'(exp_ev.size() > 0), 1);
        if (exp_ev.size() > 0) check("event", 32'({frame_ok, err_valid, err_code}), 32'(exp_ev.pop_front()));
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    u_if.valid = 1'b0;
    u_if.data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'({wr_valid, frame_ok, err_valid, err_code, wr_addr, wr_data}), 0);
    check("rst_ready", 32'(u_if.ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'h10, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("beat_seq", 32'({wr_valid, u_if.ready, wr_addr, wr_data}), 32'({1'b1, 1'b0, 8'(8'h10 + i), pl[i]}));
      @(posedge clk); #1;
    end
    check("ok_pulse", 32'({frame_ok, u_if.ready}), 32'(2'b11));
    @(posedge clk); #1;
    check("ok_once", 32'(frame_ok), 0);
    wait_drain("drain_good");
    send_frame(8'h10, 8'h01);
    check("chk_err", 32'({err_valid, err_code, wr_valid}), 32'(4'b1100));
    wait_drain("drain_chk");
    send_frame(8'h10, 8'h00);
    wait_drain("drain_after_chk");
    send(8'h00);
    send(8'hFF);
    send(8'h12);
    exp_ev.push_back(4'b0101);
    send(8'h55);
    send(8'h20);
    send(8'h00);
    check("len0_err", 32'({err_valid, err_code}), 32'(3'b101));
    @(posedge clk); #1;
    check("err_once", 32'({err_valid, err_code}), 0);
    exp_ev.push_back(4'b0101);
    send(8'h55);
    send(8'h20);
    send(8'(MAX_LEN + 1));
    check("len17_err", 32'({err_valid, err_code}), 32'(3'b101));
    wait_drain("drain_len");
    pl.delete();
    for (int i = 0; i < int'(MAX_LEN); i++) pl.push_back(8'(i * 7 + 3));
    send_frame(8'h30, 8'h00);
    wait_drain("drain_maxlen");
    pl = '{8'h5A};
    send_frame(8'h55, 8'h00);
    wait_drain("drain_len1");
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(8'hFE, 8'h00);
    wait_drain("drain_wrap");
    exp_ev.push_back(4'b0111);
    send(8'h55);
    send(8'h10);
    for (int k = 0; k <= TO; k++) begin
      check("to_wait", 32'({u_if.ready, err_valid}), 32'(2'b10));
      @(posedge clk); #1;
    end
    check("to_err", 32'({err_valid, err_code, u_if.ready}), 32'(4'b1111));
    wait_drain("drain_to");
    exp_wr.push_back({8'h10, 8'h77});
    exp_ev.push_back(4'b1000);
    send(8'h55);
    send(8'h10);
    repeat (TO) @(posedge clk);
    #1;
    send(8'h01);
    check("race_noerr", 32'(err_valid), 0);
    send(8'h77);
    send(8'h88);
    wait_drain("drain_race");
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'h40, 8'h00);
    @(posedge clk); #1;
    wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall", 32'({wr_valid, u_if.ready, wr_addr, wr_data}), 32'({1'b1, 1'b0, 8'h41, 8'hBB}));
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    wait_drain("drain_stall");
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(8'h80, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_drop", 32'({wr_valid, frame_ok, err_valid}), 0);
    rst_n = 1'b1;
    exp_wr.delete();
    exp_ev.delete();
    repeat (10) @(posedge clk);
    #1;
    check("rst_idle", 32'({u_if.ready, wr_valid}), 32'(2'b10));
    pl = '{8'hDE, 8'hAD};
    send_frame(8'h00, 8'h00);
    wait_drain("drain_post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream consumer of the UART receiver. It accepts received bytes over the `UartIF` handshake and recovers framed write commands: SOF, address, length, payload, checksum. The payload is buffered and only released as a burst of address/data writes once the checksum has been verified. Corrupt, malformed or stalled frames are dropped and reported with an error code.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate, used only to size the inter-byte timeout.
- `MAX_LEN`, default 16: maximum payload bytes per frame, range 1..255.
- `TIMEOUT_BYTES`, default 4: allowed mid-frame silence, in byte times. Timeout cycles `TO_CYC = TIMEOUT_BYTES*10*CLK_FREQ/BAUD_RATE`.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset; synchronous, active-low.
- `in`  `UartIF.slave`  —: byte stream from the receiver, signals `data[7:0]`, `valid`, `ready`.
- `wr_valid`  out  1: write beat valid.
- `wr_ready`  in  1: write sink ready.
- `wr_addr`  out  8: write address.
- `wr_data`  out  8: write data.
- `frame_ok`  out  1: one-cycle pulse, frame fully committed.
- `err_valid`  out  1: one-cycle pulse, frame dropped.
- `err_code`  out  2: reason for the drop; valid only while `err_valid` is high.

## Operation
- A byte is accepted when `in.valid && in.ready` in the same cycle.
  - Upstream `valid` is a single-cycle pulse; the parser never relies on it being held.
- Frame format: SOF = 0x55, ADDR, LEN, LEN payload bytes, CHK.
- CHK = 8-bit sum, mod 256, of ADDR, LEN and every payload byte. SOF is excluded.
- State machine:
  - IDLE: waits for SOF and discards every other byte silently. SOF moves to ADDR.
  - ADDR: latches the base address and seeds the running sum. Moves to LEN.
  - LEN: if LEN == 0 or LEN > `MAX_LEN`, raise error LEN and go to IDLE. Otherwise latch LEN and go to DATA.
  - DATA: writes the byte to buffer slot i and adds it to the sum. After LEN bytes, go to CHK.
  - CHK: match goes to COMMIT. Mismatch raises error CHK and goes to IDLE.
  - COMMIT: issues LEN write beats, `wr_addr = (ADDR + i) mod 256` and `wr_data = buf[i]`. After the last handshake, pulse `frame_ok` and go to IDLE.
- An SOF byte arriving mid-frame is treated as an ordinary field byte; there is no resynchronisation.
- Timeout: a counter clears on every accepted byte and runs in states ADDR, LEN, DATA and CHK.
  - Reaching `TO_CYC` raises error TIMEOUT and returns to IDLE.
  - If a byte is accepted in the same cycle the count expires, the byte wins: it is accepted and the counter clears.
- `err_code` values: 0 = none, 1 = LEN, 2 = CHK, 3 = TIMEOUT.
- `in.ready` is 1 in every state except COMMIT, where it is 0.

## Timing
- Reset values:
  - `wr_valid`, `frame_ok`, `err_valid`, `err_code`, `wr_addr` and `wr_data` are all 0.
  - `in.ready` is 1.
  - State is IDLE, and the sum, counters and length are 0.
- `err_valid` pulses in the cycle after the offending byte is accepted, or the cycle after the timeout expires.
- COMMIT output timing:
  - First `wr_valid` rises in the cycle after CHK is accepted.
  - Beats run back-to-back while `wr_ready` is held high, so a frame takes LEN cycles minimum.
- While `wr_valid && !wr_ready`, `wr_addr` and `wr_data` hold stable.
- `frame_ok` pulses in the cycle after the final beat handshake. `in.ready` returns to 1 in that same cycle.
- Reset asserted mid-frame or mid-COMMIT: at the next edge `wr_valid` drops, buffered data is discarded, and no `frame_ok` or `err_valid` is produced.
- Timeout counter width is `$clog2(TO_CYC+1)`. Buffer index and length width is `$clog2(MAX_LEN+1)`.

## Structure
- `uart_pkg` holds:
  - `SOF_BYTE` = 8'h55;
  - the state enum `frame_state_e` {IDLE, ADDR, LEN, DATA, CHK, COMMIT};
  - the error enum `frame_err_e` {ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT}.
- `UartIF` is reused unchanged.
- Sub-module `frame_buf`: `MAX_LEN` x 8 simple dual-port register array.
  - One write port, used in DATA.
  - One read port with registered output, used in COMMIT.
  - The COMMIT read is prefetched so the first beat still appears one cycle after CHK.

## Test plan
- Good frame 55 10 03 AA BB CC 44 -> writes (10,AA), (11,BB), (12,CC) on consecutive cycles, then `frame_ok` once; no `err_valid`.
- Same frame with CHK = 45 -> `err_valid` with `err_code` = 2 and no `wr_valid`. A following good frame then commits normally.
- Garbage 00 FF 12 followed by 55 20 00 -> the garbage is ignored, then `err_code` = 1 right after the LEN byte. LEN = `MAX_LEN`+1 gives the same result.
- Address wrap, 55 FE 03 01 02 03 07 -> writes (FE,01), (FF,02), (00,03).
- 55 10, then idle for `TO_CYC` cycles -> `err_code` = 3 and `in.ready` stays 1. Separately, a byte arriving in exactly the expiry cycle is accepted and no error is raised.
- Good frame with `wr_ready` held low for 5 cycles on beat 2 -> `wr_addr`/`wr_data` stay stable and `in.ready` stays 0 throughout COMMIT. Separately, `rst_n` pulsed mid-COMMIT -> `wr_valid` is 0 at the next edge and no `frame_ok` is produced.
